vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//   Parametrised VGA timing generator plus built-in test-pattern source, succeeding the fixed
//   640x480 solid-colour display path. Generates sync/DE/pixel coordinates for any mode from
//   parameters and drives CW-bit RGB with one of five patterns, switched glitch-free per frame.
//   Sits between the pixel-clock PLL domain and the board RGB/sync pins.
// PARAMETERS
//   HRES 640 active pixels/line     | HFP 16 | HSW 96 | HBP 48   (pixel clocks)
//   VRES 480 active lines/frame     | VFP 10 | VSW 2  | VBP 33   (lines)
//   HS_POL 0  hsync active level    | VS_POL 0 vsync active level
//   CW 4      bits per colour channel
//   CHK_LOG2 5  checkerboard cell size = 2**CHK_LOG2 pixels
//   Derived: H_TOTAL=HRES+HFP+HSW+HBP (800), V_TOTAL=VRES+VFP+VSW+VBP (525),
//   HSZ=$clog2(H_TOTAL), VSZ=$clog2(V_TOTAL)
// PORTS
//   clk_i         in  1      pixel clock
//   rst_i         in  1      synchronous reset, active high
//   mode_i        in  3      pattern select, sampled once per frame
//   color_i       in  3*CW   {r,g,b} for solid mode, sampled once per frame
//   hcount_o      out HSZ    horizontal position of current output pixel
//   vcount_o      out VSZ    vertical position of current output pixel
//   de_o          out 1      display enable (active region)
//   hsync_o       out 1      horizontal sync, level per HS_POL
//   vsync_o       out 1      vertical sync, level per VS_POL
//   r_o,g_o,b_o   out CW ea. pixel colour, forced 0 when de_o=0
//   frame_start_o out 1      1-cycle pulse coincident with pixel (0,0) on outputs
//   frame_cnt_o   out 8      frames completed, wraps 255->0
// BEHAVIOUR
//   - Internal counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); h wraps and v advances on
//     h==H_TOTAL-1; v wraps on v==V_TOTAL-1 at h wrap (frame end). frame_cnt += 1 at frame end.
//   - All outputs registered: latency 1 clk from counters; de/sync/rgb/counts mutually aligned.
//   - de = (h<HRES)&&(v<VRES). hsync active for HRES+HFP <= h < HRES+HFP+HSW;
//     vsync active for VRES+VFP <= v < VRES+VFP+VSW (whole lines).
//   - mode_q/color_q load from mode_i/color_i only on the frame-end cycle; a change mid-frame
//     never affects the current frame. Takes effect from pixel (0,0) of next frame.
//   - Patterns (FS = all-ones CW): 0 solid color_q; 1 eight vertical bars, BAR_W=HRES/8,
//     idx=h/BAR_W via comparators (no divider), clamp idx to 7 for leftover pixels,
//     r=idx[2]?FS:0, g=idx[1]?FS:0, b=idx[0]?FS:0; 2 checkerboard:
//     h[CHK_LOG2]^v[CHK_LOG2] ? FS(white) : 0; 3 horizontal grey ramp r=g=b=(h*2**CW)/HRES
//     implemented as top CW bits of h scaled by constant; 4 scrolling bars: mode 1 with
//     h replaced by (h+frame_cnt) mod HRES; 5-7 reserved: black.
//   - Outside DE r/g/b = 0 regardless of mode.
//   - Reset (any cycle, incl. mid-frame): h=v=0, frame_cnt=0, mode_q=0, color_q=0; outputs:
//     de_o=0, hsync_o=~HS_POL, vsync_o=~VS_POL, rgb=0, counts=0, frame_start_o=0.
//     First cycle after reset release outputs pixel (0,0) with frame_start_o=1 on the next clk.
//   - frame_start_o does not fire during reset; frame_cnt wrap is silent (no flag).
// CONFIGURATION
//   VGA_PAT_BORDER_EN defined: active pixels with h==0, h==HRES-1, v==0 or v==VRES-1 forced
//   to FS on all channels (white 1-pixel frame) in every mode incl. reserved; adds no latency.
//   Undefined: no override, pattern pixels at edges unchanged. Default: undefined.
// TESTING
//   1 Defaults, reset 10 clk, run 2 frames -> 800 clk/line, 525 lines/frame; hsync low for
//     exactly 96 clk starting hcount_o=656; vsync low lines 490-491; de_o high 640x480 clks.
//   2 mode_i=0, color_i=12'hF0A -> active pixels r=F,g=0,b=A; blanking rgb=0.
//   3 mode_i=1 -> hcount 0..79 black, 80..159 blue, ..., 560..639 white; mode_i=2 ->
//     (0,0) black, (32,0) white, (32,32) black.
//   4 Change mode_i 0->1 at line 200 -> rest of frame stays solid; bars from next (0,0),
//     coincident with frame_start_o.
//   5 Assert rst_i for 1 clk at h=300,v=100 -> next output all reset values, frame_cnt_o=0,
//     timing restarts at (0,0); run 256 frames -> frame_cnt_o wraps to 0.
//   6 With VGA_PAT_BORDER_EN, mode 5 -> only edge pixels FFF, interior 000; without -> all 000.

Source files
------------

// File: rtl/vga_pattern_gen_if.sv
// Video output bus of vga_pattern_gen: registered timing, coordinates and pixel colour.
// There is no valid/ready handshake: the source drives every pixel clock, de_o qualifies pixel data.
interface vga_pattern_gen_if #(
  parameter int HSZ = 10,
  parameter int VSZ = 10,
  parameter int CW  = 4
);
  logic [HSZ-1:0] hcount_o;
  logic [VSZ-1:0] vcount_o;
  logic           de_o;
  logic           hsync_o;
  logic           vsync_o;
  logic [CW-1:0]  r_o;
  logic [CW-1:0]  g_o;
  logic [CW-1:0]  b_o;
  logic           frame_start_o;
  logic [7:0]     frame_cnt_o;

  modport master (
    output hcount_o, vcount_o, de_o, hsync_o, vsync_o,
           r_o, g_o, b_o, frame_start_o, frame_cnt_o
  );

  modport slave (
    input  hcount_o, vcount_o, de_o, hsync_o, vsync_o,
           r_o, g_o, b_o, frame_start_o, frame_cnt_o
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing generator with a built-in five-pattern test source.
// Optional macro VGA_PAT_BORDER_EN: forces a white 1-pixel frame around the active area.
module vga_pattern_gen #(
  parameter int HRES     = 640,
  parameter int HFP      = 16,
  parameter int HSW      = 96,
  parameter int HBP      = 48,
  parameter int VRES     = 480,
  parameter int VFP      = 10,
  parameter int VSW      = 2,
  parameter int VBP      = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 4,
  parameter int CHK_LOG2 = 5,
  localparam int H_TOTAL = HRES + HFP + HSW + HBP,
  localparam int V_TOTAL = VRES + VFP + VSW + VBP,
  localparam int HSZ     = $clog2(H_TOTAL),
  localparam int VSZ     = $clog2(V_TOTAL)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2:0]      mode_i,
  input  logic [3*CW-1:0] color_i,
  vga_pattern_gen_if.master vid
);

  localparam int BAR_W = HRES / 8;

  // Ramp = floor(h * 2**CW / HRES) via a constant multiply; a fraction of
  // 2*HSZ bits keeps the rounding error below the smallest step for h < HRES.
  localparam int          RAMP_S = 2 * HSZ;
  localparam logic [63:0] RAMP_K = ((64'd1 << (RAMP_S + CW)) + 64'(HRES) - 64'd1) / 64'(HRES);

  localparam logic [3*CW-1:0] WHITE = {(3*CW){1'b1}};

  logic [HSZ-1:0]  h;
  logic [VSZ-1:0]  v;
  logic [7:0]      frame_cnt;
  logic [2:0]      mode_q;
  logic [3*CW-1:0] color_q;
  logic [HSZ-1:0]  scroll_off;

  logic            line_end;
  logic            frame_end;
  logic            de_c;
  logic            hs_act;
  logic            vs_act;
  logic [CW-1:0]   ramp;
  logic [31:0]     scroll_x;
  logic [3*CW-1:0] pix;

  function automatic logic [2:0] bar_idx(input logic [31:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 32'(i * BAR_W)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3*CW-1:0] bar_rgb(input logic [2:0] idx);
    return {{CW{idx[2]}}, {CW{idx[1]}}, {CW{idx[0]}}};
  endfunction

  assign line_end  = (32'(h) == 32'(H_TOTAL - 1));
  assign frame_end = line_end && (32'(v) == 32'(V_TOTAL - 1));

  // Counters, per-frame pattern settings and the scroll offset, which tracks
  // frame_cnt mod HRES incrementally so the scrolling pattern needs no divider.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h          <= '0;
      v          <= '0;
      frame_cnt  <= '0;
      mode_q     <= '0;
      color_q    <= '0;
      scroll_off <= '0;
    end else begin
      h <= line_end ? '0 : h + 1'b1;
      if (line_end) v <= frame_end ? '0 : v + 1'b1;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 8'd1;
        mode_q    <= mode_i;
        color_q   <= color_i;
        if (frame_cnt == 8'hFF || 32'(scroll_off) == 32'(HRES - 1)) scroll_off <= '0;
        else                                                          scroll_off <= scroll_off + 1'b1;
      end
    end
  end

  assign de_c   = (32'(h) < 32'(HRES)) && (32'(v) < 32'(VRES));
  assign hs_act = (32'(h) >= 32'(HRES + HFP)) && (32'(h) < 32'(HRES + HFP + HSW));
  assign vs_act = (32'(v) >= 32'(VRES + VFP)) && (32'(v) < 32'(VRES + VFP + VSW));
  assign ramp   = CW'((64'(h) * RAMP_K) >> RAMP_S);

  // Both operands are below HRES inside the active area, so one subtract wraps.
  always_comb begin
    scroll_x = 32'(h) + 32'(scroll_off);
    if (scroll_x >= 32'(HRES)) scroll_x = scroll_x - 32'(HRES);
  end

  always_comb begin
    pix = '0;
    case (mode_q)
      3'd0:    pix = color_q;
      3'd1:    pix = bar_rgb(bar_idx(32'(h)));
      3'd2:    pix = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? WHITE : '0;
      3'd3:    pix = {3{ramp}};
      3'd4:    pix = bar_rgb(bar_idx(scroll_x));
      default: pix = '0;
    endcase
`ifdef VGA_PAT_BORDER_EN
    if (h == '0 || 32'(h) == 32'(HRES - 1) || v == '0 || 32'(v) == 32'(VRES - 1)) pix = WHITE;
`endif
    if (!de_c) pix = '0;
  end

  // Single output register stage keeps every output aligned to the same pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vid.hcount_o      <= '0;
      vid.vcount_o      <= '0;
      vid.de_o          <= 1'b0;
      vid.hsync_o       <= ~HS_POL;
      vid.vsync_o       <= ~VS_POL;
      vid.r_o           <= '0;
      vid.g_o           <= '0;
      vid.b_o           <= '0;
      vid.frame_start_o <= 1'b0;
      vid.frame_cnt_o   <= '0;
    end else begin
      vid.hcount_o      <= h;
      vid.vcount_o      <= v;
      vid.de_o          <= de_c;
      vid.hsync_o       <= hs_act ? HS_POL : ~HS_POL;
      vid.vsync_o       <= vs_act ? VS_POL : ~VS_POL;
      vid.r_o           <= pix[3*CW-1:2*CW];
      vid.g_o           <= pix[2*CW-1:CW];
      vid.b_o           <= pix[CW-1:0];
      vid.frame_start_o <= (h == '0) && (v == '0);
      vid.frame_cnt_o   <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a small video mode: per-cycle model check plus directed literal checks.
module tb_vga_pattern_gen;

  localparam int HRES = 18, HFP = 1, HSW = 2, HBP = 1;
  localparam int VRES = 6,  VFP = 1, VSW = 1, VBP = 1;
  localparam int CW = 4, CHK = 2;
  localparam int HT = HRES + HFP + HSW + HBP;   // 22
  localparam int VT = VRES + VFP + VSW + VBP;   // 9
  localparam int FT = HT * VT;                  // 198
  localparam int HSZ = $clog2(HT);
  localparam int VSZ = $clog2(VT);
  localparam int BAR_W = HRES / 8;

`ifdef VGA_PAT_BORDER_EN
  localparam logic [11:0] EDGE_RGB = 12'hFFF;
`else
  localparam logic [11:0] EDGE_RGB = 12'h000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mode_i = 3'd0;
  logic [11:0] color_i = 12'h000;

  int total = 0;
  int bad = 0;

  vga_pattern_gen_if #(.HSZ(HSZ), .VSZ(VSZ), .CW(CW)) vid ();

  vga_pattern_gen #(
    .HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VRES(VRES), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .CHK_LOG2(CHK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_i), .color_i(color_i), .vid(vid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model: positions counted from reset release ----------------
  int          n = 0;
  bit          started = 0;
  bit          last_rst = 1;
  int          mode_of [0:511];
  logic [11:0] color_of[0:511];

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      last_rst    = 1;
      n           = 0;
      mode_of[0]  = 0;
      color_of[0] = 12'h000;
    end else begin
      last_rst = 0;
      n++;
      if (n % FT == 0 && n / FT < 512) begin
        mode_of[n / FT]  = int'(mode_i);
        color_of[n / FT] = color_i;
      end
    end
  end

  // {hcount, vcount, de, hsync, vsync, r, g, b, frame_start, frame_cnt}
  function automatic logic [32:0] model(input int p);
    int f, h, v, fc, md, idx, x;
    logic [11:0] c;
    logic de, hs, vs, fs;
    f  = p / FT;
    h  = p % HT;
    v  = (p / HT) % VT;
    fc = f % 256;
    md = mode_of[f];
    de = (h < HRES) && (v < VRES);
    hs = !((h >= HRES + HFP) && (h < HRES + HFP + HSW));
    vs = !((v >= VRES + VFP) && (v < VRES + VFP + VSW));
    fs = (p % FT == 0);
    c  = 12'h000;
    case (md)
      0: c = color_of[f];
      1, 4: begin
        x = (md == 4) ? (h + fc) % HRES : h;
        idx = x / BAR_W;
        if (idx > 7) idx = 7;
        c = {((idx & 4) != 0) ? 4'hF : 4'h0, ((idx & 2) != 0) ? 4'hF : 4'h0, ((idx & 1) != 0) ? 4'hF : 4'h0};
      end
      2: c = ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 12'hFFF : 12'h000;
      3: c = {3{4'((h * 16) / HRES)}};
      default: c = 12'h000;
    endcase
`ifdef VGA_PAT_BORDER_EN
    if (h == 0 || h == HRES - 1 || v == 0 || v == VRES - 1) c = 12'hFFF;
`endif
    if (!de) c = 12'h000;
    return {5'(h), 4'(v), de, hs, vs, c, fs, 8'(fc)};
  endfunction

  // ---------------- scoreboard: one compare per cycle ----------------
  logic [32:0] exp_q[$];

  always @(negedge clk) begin
    logic [32:0] act, expv;
    if (started) begin
      if (last_rst) exp_q.push_back({5'd0, 4'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 8'd0});
      else          exp_q.push_back(model(n - 1));
      expv = exp_q.pop_front();
      act  = {vid.hcount_o, vid.vcount_o, vid.de_o, vid.hsync_o, vid.vsync_o,
              vid.r_o, vid.g_o, vid.b_o, vid.frame_start_o, vid.frame_cnt_o};
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL pix n=%0d rst=%0d: got %h expected %h", n, last_rst, act, expv);
      end
    end
  end

  // ---------------- driver / directed tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic wait_fs();
    int k;
    for (k = 0; k < 2 * FT; k++) begin
      @(negedge clk);
      if (vid.frame_start_o === 1'b1) break;
    end
    if (k == 2 * FT) begin
      total++; bad++;
      $display("FAIL wait_fs: no frame_start within %0d cycles expected a pulse", 2 * FT);
    end
  endtask

  task automatic wait_pixel(input int hh, input int vv);
    int k;
    for (k = 0; k < 2 * FT; k++) begin
      @(negedge clk);
      if (int'(vid.hcount_o) == hh && int'(vid.vcount_o) == vv) break;
    end
    if (k == 2 * FT) begin
      total++; bad++;
      $display("FAIL wait_pixel(%0d,%0d): not reached within %0d cycles", hh, vv, 2 * FT);
    end
  endtask

  task automatic check_rgb(input string name, input int hh, input int vv, input logic [11:0] expv);
    wait_pixel(hh, vv);
    check(name, 32'({vid.r_o, vid.g_o, vid.b_o}), 32'(expv));
  endtask

  initial begin
    int de_cnt, hs_lo, vs_lo, hs_start, vs_start, fs_cnt, k;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_hsync", 32'(vid.hsync_o), 32'd1);
    check("reset_de", 32'(vid.de_o), 32'd0);
    rst = 1'b0;

    // frame timing
    wait_fs();
    check("first_fs_hcount", 32'(vid.hcount_o), 32'd0);
    de_cnt = 0; hs_lo = 0; vs_lo = 0; hs_start = -1; vs_start = -1;
    for (int i = 0; i < FT; i++) begin
      if (vid.de_o) de_cnt++;
      if (!vid.hsync_o) begin
        hs_lo++;
        if (hs_start < 0) hs_start = int'(vid.hcount_o);
      end
      if (!vid.vsync_o) begin
        vs_lo++;
        if (vs_start < 0) vs_start = int'(vid.vcount_o);
      end
      @(negedge clk);
    end
    check("de_count", 32'(de_cnt), 32'd108);
    check("hsync_low_count", 32'(hs_lo), 32'd18);
    check("hsync_start", 32'(hs_start), 32'd19);
    check("vsync_low_count", 32'(vs_lo), 32'd22);
    check("vsync_line", 32'(vs_start), 32'd7);
    check("next_frame_fs", 32'(vid.frame_start_o), 32'd1);
    check("frame_cnt_1", 32'(vid.frame_cnt_o), 32'd1);

    // solid colour
    mode_i = 3'd0; color_i = 12'hF0A;
    wait_fs();
    check_rgb("solid_active", 5, 2, 12'hF0A);
    check_rgb("solid_blank", 19, 2, 12'h000);

    // vertical bars, including the clamped leftover columns
    mode_i = 3'd1;
    wait_fs();
    check_rgb("bars_h1", 1, 2, 12'h000);
    check_rgb("bars_h2", 2, 2, 12'h00F);
    check_rgb("bars_h8", 8, 2, 12'hF00);
    check_rgb("bars_h16_clamp", 16, 2, 12'hFFF);

    // checkerboard
    mode_i = 3'd2;
    wait_fs();
    check_rgb("chk_1_1", 1, 1, 12'h000);
    check_rgb("chk_4_1", 4, 1, 12'hFFF);
    check_rgb("chk_4_4", 4, 4, 12'h000);

    // grey ramp
    mode_i = 3'd3;
    wait_fs();
    check_rgb("ramp_h7", 7, 2, 12'h666);
    check_rgb("ramp_h9", 9, 2, 12'h888);
    check_rgb("ramp_h16", 16, 2, 12'hEEE);

    // reserved mode
    mode_i = 3'd5;
    wait_fs();
    check_rgb("rsvd_edge", 0, 2, EDGE_RGB);
    check_rgb("rsvd_inner", 3, 2, 12'h000);

    // scrolling bars for one frame
    mode_i = 3'd4;
    wait_fs();
    wait_fs();

    // mid-frame mode change applies only from the next frame start
    mode_i = 3'd0; color_i = 12'hF0A;
    wait_fs();
    wait_pixel(0, 3);
    mode_i = 3'd1;
    check_rgb("midchange_same_frame", 8, 4, 12'hF0A);
    wait_fs();
    check("midchange_fs_rgb", 32'({vid.r_o, vid.g_o, vid.b_o}), 32'(EDGE_RGB));
    check_rgb("midchange_next_frame", 2, 1, 12'h00F);

    // one-cycle reset mid-frame
    wait_pixel(10, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_hcount", 32'(vid.hcount_o), 32'd0);
    check("rst_vsync", 32'(vid.vsync_o), 32'd1);
    check("rst_fc", 32'(vid.frame_cnt_o), 32'd0);
    check("rst_fs", 32'(vid.frame_start_o), 32'd0);
    @(negedge clk);
    check("post_rst_fs", 32'(vid.frame_start_o), 32'd1);

    // frame counter wrap, with scrolling bars running the whole time
    mode_i = 3'd4;
    fs_cnt = 1;
    for (k = 0; k < 260 * FT; k++) begin
      @(negedge clk);
      if (vid.frame_start_o) begin
        fs_cnt++;
        if (fs_cnt == 256) check("fc_255", 32'(vid.frame_cnt_o), 32'd255);
        if (fs_cnt == 257) begin
          check("fc_wrap", 32'(vid.frame_cnt_o), 32'd0);
          break;
        end
      end
    end
    if (k == 260 * FT) begin
      total++; bad++;
      $display("FAIL fc_wrap_timeout: saw %0d frame starts expected 257", fs_cnt);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
